// File: rtl/sseg_pkg.sv
// Shared types and the hex segment decoder for the seven-segment display blocks.
// Segment order is {a,b,c,d,e,f,g}, active-high before the pin inversion.
package sseg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'b0;

   function automatic seg_t hex_to_seg(input logic [3:0] hex);
      seg_t seg;
      case (hex)
         4'h0:    seg = 7'b1111110;
         4'h1:    seg = 7'b0110000;
         4'h2:    seg = 7'b1101101;
         4'h3:    seg = 7'b1111001;
         4'h4:    seg = 7'b0110011;
         4'h5:    seg = 7'b1011011;
         4'h6:    seg = 7'b1011111;
         4'h7:    seg = 7'b1110000;
         4'h8:    seg = 7'b1111111;
         4'h9:    seg = 7'b1111011;
         4'hA:    seg = 7'b1110111;
         4'hB:    seg = 7'b0011111;
         4'hC:    seg = 7'b1001110;
         4'hD:    seg = 7'b0111101;
         4'hE:    seg = 7'b1001111;
         4'hF:    seg = 7'b1000111;
         default: seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Prescaler for display scanning: counts 0..TICK_DIV-1 and flags the wrap cycle.
// The tick is high for exactly one clock out of every TICK_DIV.
module sseg_tick_gen #(
   parameter int TICK_DIV = 5000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner: digit buffer, hex decode, 16-level PWM, enable.
// Define SSEG_LZ_BLANK_EN to blank leading zero digits (last digit always shown).
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int TICK_DIV = 5000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [3:0]                 bright,
   input  logic                       wr_en,
   input  logic [$clog2(DIGITS)-1:0]  wr_addr,
   input  logic [3:0]                 wr_data,
   input  logic                       wr_dp,
   output logic [7:0]                 cathodes,
   output logic [DIGITS-1:0]          anodes
);

   localparam int AW = $clog2(DIGITS);
   localparam logic [AW-1:0] IDX_LAST = AW'(DIGITS - 1);
   localparam logic [AW:0]   DIG_CNT  = (AW + 1)'(DIGITS);

   logic              tick;
   logic [3:0]        sub;
   logic [AW-1:0]     idx;
   logic [AW-1:0]     rev_idx;
   logic [3:0]        dig_data [DIGITS];
   logic [DIGITS-1:0] dig_dp;
   logic [DIGITS-1:0] lz_blank;
   logic              lit;
   logic [DIGITS-1:0] anode_nxt;
   logic [7:0]        cath_nxt;

   sseg_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Digit index only moves when the PWM sub-slot rolls over.
   always_ff @(posedge clk) begin
      if (rst) begin
         sub <= '0;
         idx <= '0;
      end else if (tick) begin
         sub <= sub + 4'd1;
         if (sub == 4'hF) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            dig_data[i] <= 4'h0;
         end
         dig_dp <= '0;
      end else if (wr_en && ({1'b0, wr_addr} < DIG_CNT)) begin
         dig_data[wr_addr] <= wr_data;
         dig_dp[wr_addr]   <= wr_dp;
      end
   end

`ifdef SSEG_LZ_BLANK_EN
   logic lz_seen;

   // A digit stays blank while every digit up to and including it is 0 with no dp.
   always_comb begin
      lz_seen  = 1'b0;
      lz_blank = '0;
      for (int i = 0; i < DIGITS - 1; i++) begin
         lz_seen     = lz_seen | (dig_data[i] != 4'h0) | dig_dp[i];
         lz_blank[i] = ~lz_seen;
      end
   end
`else
   assign lz_blank = '0;
`endif

   always_comb begin
      rev_idx   = IDX_LAST - idx;
      lit       = en && (sub <= bright) && !lz_blank[idx];
      anode_nxt = '1;
      cath_nxt  = ~{SEG_OFF, 1'b0};
      if (lit) begin
         anode_nxt[rev_idx] = 1'b0;
         cath_nxt           = ~{hex_to_seg(dig_data[idx]), dig_dp[idx]};
      end
   end

   // Segments and digit select share one register so they can never skew.
   always_ff @(posedge clk) begin
      if (rst) begin
         anodes   <= '1;
         cathodes <= '1;
      end else begin
         anodes   <= anode_nxt;
         cathodes <= cath_nxt;
      end
   end

endmodule
